// File: rtl/mm_pkg.sv
// mm_pkg: shared FP32 operand type, zero constant and feeder state encoding.
// Also imported by the downstream result collector.
package mm_pkg;
   typedef logic [31:0] fp32_t;
   localparam fp32_t FP_ZERO = 32'h0000_0000;
   typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} feeder_state_t;
endpackage

// File: rtl/systolic_feeder_if.sv
// systolic_feeder_if: operand write port, control and PE-edge bus of the feeder.
// master: drives wr_*, start, pe_overflow; observes lanes, enables and status.
// slave : the feeder itself.
interface systolic_feeder_if #(parameter int N = 4);
   localparam int AW = $clog2(N*N);
   logic             wr_en;
   logic             wr_sel;
   logic [AW-1:0]    wr_addr;
   mm_pkg::fp32_t    wr_data;
   logic             start;
   logic             pe_overflow;
   logic [N*32-1:0]  a_lane;
   logic [N*32-1:0]  b_lane;
   logic             acc_clr;
   logic             mult_en;
   logic             add_en;
   logic             out_en;
   logic             busy;
   logic             done;
   logic             wr_rej;
   logic             ovf_flag;
   modport master (output wr_en, wr_sel, wr_addr, wr_data, start, pe_overflow,
                   input a_lane, b_lane, acc_clr, mult_en, add_en, out_en, busy, done, wr_rej, ovf_flag);
   modport slave  (input wr_en, wr_sel, wr_addr, wr_data, start, pe_overflow,
                   output a_lane, b_lane, acc_clr, mult_en, add_en, out_en, busy, done, wr_rej, ovf_flag);
endinterface

// File: rtl/enable_delay.sv
// enable_delay: DEPTH-cycle single-bit delay line with async active-high reset.
// Ports: clk, reset, d_i (input bit), q_o (d_i delayed by DEPTH cycles).
module enable_delay #(parameter int DEPTH = 1) (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);
   logic [DEPTH-1:0] sr_q;
   always_ff @(posedge clk or posedge reset)
      if (reset) sr_q <= '0;
      else       sr_q <= (sr_q << 1) | DEPTH'(d_i);
   assign q_o = sr_q[DEPTH-1];
endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: holds A/B operand banks and streams them diagonally skewed into an N x N systolic array.
// Ports: clk, reset (async, active-high), bus (systolic_feeder_if.slave: write port, start,
// pe_overflow in; skewed lanes, PE enables, acc_clr, busy, done, wr_rej, ovf_flag out).
module systolic_feeder import mm_pkg::*; #(
   parameter int N         = 4,
   parameter int MULT_LAT  = 1,
   parameter int ADD_LAT   = 1,
   parameter int DRAIN_CYC = 8
) (
   input logic clk,
   input logic reset,
   systolic_feeder_if.slave bus
);
   localparam int AW = $clog2(N*N);
   localparam int CW = $clog2(2*N + DRAIN_CYC);
   feeder_state_t   state_q;
   logic [CW-1:0]   cnt_q;
   fp32_t           a_q [N*N];
   fp32_t           b_q [N*N];
   logic [N*32-1:0] a_lane_q, b_lane_q, a_lane_d, b_lane_d;
   logic            acc_clr_q, mult_en_q, busy_q, done_q, wr_rej_q, ovf_q;
   logic            idle, stream_last, load_lanes, wr_ok, add_en_w, out_en_w;
   int              t_nxt;
   assign idle        = state_q == IDLE;
   assign stream_last = state_q == STREAM && cnt_q == CW'(2*N - 2);
   // Lanes are registered, so they are computed for the stream index of the coming cycle.
   assign load_lanes  = state_q == CLEAR || (state_q == STREAM && !stream_last);
   assign t_nxt       = state_q == CLEAR ? 0 : int'(cnt_q) + 1;
   assign wr_ok       = bus.wr_en && idle && ({1'b0, bus.wr_addr} < (AW+1)'(N*N));
   always_comb begin
      a_lane_d = '0;
      b_lane_d = '0;
      for (int i = 0; i < N; i++)
         if (load_lanes && t_nxt >= i && t_nxt < i + N) begin
            a_lane_d[32*i +: 32] = a_q[AW'(i*N + t_nxt - i)];
            b_lane_d[32*i +: 32] = b_q[AW'((t_nxt - i)*N + i)];
         end
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         a_q       <= '{default: FP_ZERO};
         b_q       <= '{default: FP_ZERO};
         a_lane_q  <= '0;
         b_lane_q  <= '0;
         acc_clr_q <= 1'b0;
         mult_en_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         wr_rej_q  <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         a_lane_q <= a_lane_d;
         b_lane_q <= b_lane_d;
         wr_rej_q <= bus.wr_en && !wr_ok;
         if (wr_ok && bus.wr_sel)  b_q[bus.wr_addr] <= bus.wr_data;
         if (wr_ok && !bus.wr_sel) a_q[bus.wr_addr] <= bus.wr_data;
         ovf_q <= (idle && bus.start) ? 1'b0 : ovf_q | (bus.pe_overflow && busy_q);
         case (state_q)
            IDLE:
               if (bus.start) begin
                  state_q   <= CLEAR;
                  acc_clr_q <= 1'b1;
                  busy_q    <= 1'b1;
               end
            CLEAR: begin
               state_q   <= STREAM;
               cnt_q     <= '0;
               acc_clr_q <= 1'b0;
               mult_en_q <= 1'b1;
            end
            STREAM:
               if (stream_last) begin
                  state_q   <= DRAIN;
                  cnt_q     <= '0;
                  mult_en_q <= 1'b0;
               end else cnt_q <= cnt_q + 1'b1;
            DRAIN:
               if (cnt_q == CW'(DRAIN_CYC - 1)) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end else cnt_q <= cnt_q + 1'b1;
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   enable_delay #(.DEPTH(MULT_LAT)) u_add_dly (.clk(clk), .reset(reset), .d_i(mult_en_q), .q_o(add_en_w));
   enable_delay #(.DEPTH(ADD_LAT))  u_out_dly (.clk(clk), .reset(reset), .d_i(add_en_w),  .q_o(out_en_w));
   assign bus.a_lane   = a_lane_q;
   assign bus.b_lane   = b_lane_q;
   assign bus.acc_clr  = acc_clr_q;
   assign bus.mult_en  = mult_en_q;
   assign bus.add_en   = add_en_w;
   assign bus.out_en   = out_en_w;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.wr_rej   = wr_rej_q;
   assign bus.ovf_flag = ovf_q;
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: directed bench for systolic_feeder (N=2 main instance, N=3 for out-of-range addresses).
module tb_systolic_feeder;
   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   always #5 clk = ~clk;
   systolic_feeder_if #(.N(2)) bus2 ();
   systolic_feeder_if #(.N(3)) bus3 ();
   systolic_feeder #(.N(2), .MULT_LAT(1), .ADD_LAT(1), .DRAIN_CYC(8)) dut (.clk(clk), .reset(reset), .bus(bus2));
   systolic_feeder #(.N(3), .MULT_LAT(1), .ADD_LAT(1), .DRAIN_CYC(8)) dut3 (.clk(clk), .reset(reset), .bus(bus3));
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
   task tick;
      @(posedge clk);
      #1;
      cyc++;
   endtask
   task wr2(input logic sel, input logic [1:0] addr, input logic [31:0] data);
      bus2.wr_en = 1'b1;
      bus2.wr_sel = sel;
      bus2.wr_addr = addr;
      bus2.wr_data = data;
      tick;
      bus2.wr_en = 1'b0;
      total++;
      if (bus2.wr_rej !== 1'b0) begin
         bad++;
         $display("FAIL load_wr_rej addr=%0d got=%b exp=0", addr, bus2.wr_rej);
      end
   endtask
   task test_reset;
      reset = 1'b1;
      tick;
      tick;
      total++;
      if ({bus2.a_lane, bus2.b_lane} !== 128'h0) begin
         bad++;
         $display("FAIL reset_lanes got=%h exp=0", {bus2.a_lane, bus2.b_lane});
      end
      total++;
      if ({bus2.acc_clr, bus2.mult_en, bus2.add_en, bus2.out_en, bus2.busy, bus2.done, bus2.wr_rej, bus2.ovf_flag} !== 8'h00) begin
         bad++;
         $display("FAIL reset_ctrl got=%b exp=00000000",
                  {bus2.acc_clr, bus2.mult_en, bus2.add_en, bus2.out_en, bus2.busy, bus2.done, bus2.wr_rej, bus2.ovf_flag});
      end
      reset = 1'b0;
      tick;
   endtask
   task test_stream;
      logic [63:0] ea [5];
      logic [63:0] eb [5];
      ea = '{64'h0, 64'h0, 64'h0000_0000_3F80_0000, 64'h4040_0000_4000_0000, 64'h4080_0000_0000_0000};
      eb = '{64'h0, 64'h0, 64'h0000_0000_3F80_0000, 64'h0, 64'h3F80_0000_0000_0000};
      cyc = 0;
      bus2.start = 1'b1;
      tick;
      bus2.start = 1'b0;
      while (cyc <= 4) begin
         total++;
         if (bus2.a_lane !== ea[cyc]) begin
            bad++;
            $display("FAIL stream_a cyc=%0d got=%h exp=%h", cyc, bus2.a_lane, ea[cyc]);
         end
         total++;
         if (bus2.b_lane !== eb[cyc]) begin
            bad++;
            $display("FAIL stream_b cyc=%0d got=%h exp=%h", cyc, bus2.b_lane, eb[cyc]);
         end
         total++;
         if ({bus2.acc_clr, bus2.mult_en, bus2.add_en, bus2.out_en, bus2.busy} !== {cyc == 1, cyc >= 2, cyc >= 3, cyc == 4, 1'b1}) begin
            bad++;
            $display("FAIL stream_ctrl cyc=%0d got=%b exp=%b", cyc,
                     {bus2.acc_clr, bus2.mult_en, bus2.add_en, bus2.out_en, bus2.busy},
                     {cyc == 1, cyc >= 2, cyc >= 3, cyc == 4, 1'b1});
         end
         tick;
      end
   endtask
   task test_refused_ovf;
      bus2.wr_en = 1'b1;
      bus2.wr_sel = 1'b0;
      bus2.wr_addr = 2'd0;
      bus2.wr_data = 32'h4120_0000;
      total++;
      if ({bus2.a_lane, bus2.b_lane, bus2.mult_en, bus2.add_en, bus2.out_en} !== {128'h0, 3'b011}) begin
         bad++;
         $display("FAIL drain_c5 got=%h exp=%h", {bus2.a_lane, bus2.b_lane, bus2.mult_en, bus2.add_en, bus2.out_en}, {128'h0, 3'b011});
      end
      tick;
      bus2.wr_en = 1'b0;
      total++;
      if ({bus2.wr_rej, bus2.add_en, bus2.out_en} !== 3'b101) begin
         bad++;
         $display("FAIL busy_wr_rej cyc=%0d got=%b exp=101", cyc, {bus2.wr_rej, bus2.add_en, bus2.out_en});
      end
      bus2.start = 1'b1;
      tick;
      bus2.start = 1'b0;
      total++;
      if ({bus2.wr_rej, bus2.out_en} !== 2'b00) begin
         bad++;
         $display("FAIL wr_rej_pulse cyc=%0d got=%b exp=00", cyc, {bus2.wr_rej, bus2.out_en});
      end
      bus2.pe_overflow = 1'b1;
      tick;
      bus2.pe_overflow = 1'b0;
      total++;
      if (bus2.ovf_flag !== 1'b1) begin
         bad++;
         $display("FAIL ovf_set cyc=%0d got=%b exp=1", cyc, bus2.ovf_flag);
      end
      tick;
   endtask
   task test_drain_done;
      while (cyc <= 20) begin
         total++;
         if ({bus2.done, bus2.busy, bus2.ovf_flag, bus2.mult_en} !== {cyc == 13, cyc <= 13, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL drain_done cyc=%0d got=%b exp=%b", cyc,
                     {bus2.done, bus2.busy, bus2.ovf_flag, bus2.mult_en}, {cyc == 13, cyc <= 13, 1'b1, 1'b0});
         end
         tick;
      end
   endtask
   task test_next_run;
      cyc = 0;
      bus2.start = 1'b1;
      tick;
      bus2.start = 1'b0;
      total++;
      if ({bus2.ovf_flag, bus2.busy} !== 2'b01) begin
         bad++;
         $display("FAIL ovf_clear got=%b exp=01", {bus2.ovf_flag, bus2.busy});
      end
      tick;
      total++;
      if (bus2.a_lane !== 64'h0000_0000_3F80_0000) begin
         bad++;
         $display("FAIL a00_kept got=%h exp=%h", bus2.a_lane, 64'h0000_0000_3F80_0000);
      end
      for (int k = 0; k < 30 && !bus2.done; k++) tick;
      total++;
      if (cyc !== 13) begin
         bad++;
         $display("FAIL run2_done_cycle got=%0d exp=13", cyc);
      end
      tick;
   endtask
   task test_bad_addr;
      bus3.wr_en = 1'b1;
      bus3.wr_sel = 1'b0;
      bus3.wr_addr = 4'd9;
      bus3.wr_data = 32'hDEAD_BEEF;
      tick;
      bus3.wr_sel = 1'b1;
      bus3.wr_addr = 4'd15;
      total++;
      if (bus3.wr_rej !== 1'b1) begin
         bad++;
         $display("FAIL bad_addr_a got=%b exp=1", bus3.wr_rej);
      end
      tick;
      bus3.wr_sel = 1'b0;
      bus3.wr_addr = 4'd0;
      bus3.wr_data = 32'h3F80_0000;
      total++;
      if (bus3.wr_rej !== 1'b1) begin
         bad++;
         $display("FAIL bad_addr_b got=%b exp=1", bus3.wr_rej);
      end
      tick;
      bus3.wr_en = 1'b0;
      total++;
      if (bus3.wr_rej !== 1'b0) begin
         bad++;
         $display("FAIL good_addr_rej got=%b exp=0", bus3.wr_rej);
      end
      cyc = 0;
      bus3.start = 1'b1;
      tick;
      bus3.start = 1'b0;
      tick;
      total++;
      if ({bus3.a_lane, bus3.b_lane} !== {96'h0000_0000_0000_0000_3F80_0000, 96'h0}) begin
         bad++;
         $display("FAIL n3_t0 got=%h exp=%h", {bus3.a_lane, bus3.b_lane}, {96'h0000_0000_0000_0000_3F80_0000, 96'h0});
      end
      tick;
      total++;
      if ({bus3.a_lane, bus3.b_lane} !== 192'h0) begin
         bad++;
         $display("FAIL n3_t1 got=%h exp=0", {bus3.a_lane, bus3.b_lane});
      end
      for (int k = 0; k < 30 && !bus3.done; k++) tick;
      total++;
      if (cyc !== 15) begin
         bad++;
         $display("FAIL n3_done_cycle got=%0d exp=15", cyc);
      end
      tick;
   endtask
   task test_reset_abort;
      int seen;
      cyc = 0;
      bus2.start = 1'b1;
      tick;
      bus2.start = 1'b0;
      tick;
      tick;
      total++;
      if ({bus2.mult_en, bus2.a_lane} !== {1'b1, 64'h4040_0000_4000_0000}) begin
         bad++;
         $display("FAIL abort_pre got=%h exp=%h", {bus2.mult_en, bus2.a_lane}, {1'b1, 64'h4040_0000_4000_0000});
      end
      reset = 1'b1;
      #1;
      total++;
      if ({bus2.a_lane, bus2.b_lane, bus2.acc_clr, bus2.mult_en, bus2.add_en, bus2.out_en,
           bus2.busy, bus2.done, bus2.wr_rej, bus2.ovf_flag} !== 136'h0) begin
         bad++;
         $display("FAIL abort_async got=%h exp=0", {bus2.a_lane, bus2.b_lane, bus2.acc_clr, bus2.mult_en,
                  bus2.add_en, bus2.out_en, bus2.busy, bus2.done, bus2.wr_rej, bus2.ovf_flag});
      end
      tick;
      tick;
      reset = 1'b0;
      seen = 0;
      for (int k = 0; k < 15; k++) begin
         if (bus2.done) seen++;
         tick;
      end
      total++;
      if (seen !== 0) begin
         bad++;
         $display("FAIL abort_no_done got=%0d exp=0", seen);
      end
      cyc = 0;
      bus2.start = 1'b1;
      tick;
      bus2.start = 1'b0;
      tick;
      while (cyc <= 4) begin
         total++;
         if ({bus2.mult_en, bus2.a_lane, bus2.b_lane} !== {1'b1, 128'h0}) begin
            bad++;
            $display("FAIL abort_zero_lanes cyc=%0d got=%h exp=%h", cyc, {bus2.mult_en, bus2.a_lane, bus2.b_lane}, {1'b1, 128'h0});
         end
         tick;
      end
      for (int k = 0; k < 30 && !bus2.done; k++) tick;
      total++;
      if (cyc !== 13) begin
         bad++;
         $display("FAIL abort_rerun_done got=%0d exp=13", cyc);
      end
      tick;
   endtask
   initial begin
      bus2.wr_en = 1'b0;
      bus2.wr_sel = 1'b0;
      bus2.wr_addr = '0;
      bus2.wr_data = '0;
      bus2.start = 1'b0;
      bus2.pe_overflow = 1'b0;
      bus3.wr_en = 1'b0;
      bus3.wr_sel = 1'b0;
      bus3.wr_addr = '0;
      bus3.wr_data = '0;
      bus3.start = 1'b0;
      bus3.pe_overflow = 1'b0;
      test_reset;
      wr2(1'b0, 2'd0, 32'h3F80_0000);
      wr2(1'b0, 2'd1, 32'h4000_0000);
      wr2(1'b0, 2'd2, 32'h4040_0000);
      wr2(1'b0, 2'd3, 32'h4080_0000);
      wr2(1'b1, 2'd0, 32'h3F80_0000);
      wr2(1'b1, 2'd3, 32'h3F80_0000);
      test_stream;
      test_refused_ovf;
      test_drain_done;
      test_next_run;
      test_bad_addr;
      test_reset_abort;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
